// File: rtl/memory_write_arbiter.sv
// Round-robin arbiter sharing one memory write port among NUM_REQ requesters, one transaction in flight.
// Address is held toward memory until the response or a timeout; completion is a one-cycle valid pulse.
package arv_pkg;
  parameter int PHY_ADDR_SIZE = 32;
  parameter int XLEN          = 32;
endpackage

module memory_write_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_REQ-1:0]                        req_wr_en_i,
  input  logic [NUM_REQ*arv_pkg::PHY_ADDR_SIZE-1:0] req_wr_addr_i,
  output logic [arv_pkg::XLEN-1:0]                  req_wr_data_o,
  output logic [NUM_REQ-1:0]                        req_wr_valid_o,
  output logic                                      mem_wr_en_o,
  output logic [arv_pkg::PHY_ADDR_SIZE-1:0]         mem_wr_addr_o,
  input  logic [arv_pkg::XLEN-1:0]                  mem_wr_data_i,
  input  logic                                      mem_wr_valid_i,
  output logic [NUM_REQ-1:0]                        grant_o,
  output logic                                      busy_o,
  output logic                                      timeout_o
);
  localparam int AW = arv_pkg::PHY_ADDR_SIZE;
  localparam int DW = arv_pkg::XLEN;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     r_grant;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_data;
  logic [CW-1:0]     r_to_cnt;
  logic              r_to_flag;

  logic [AW-1:0]     w_addr_arr [NUM_REQ];
  logic [GW-1:0]     w_win_idx;
  logic [GW-1:0]     w_scan_idx;
  logic              w_win_vld;
  logic              w_to_hit;
  logic [GW-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0] w_grant_oh;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign w_addr_arr[g] = req_wr_addr_i[g*AW +: AW];
  end

  // Scan from the highest offset down so the slot closest to rr_ptr is the last (winning) write.
  always_comb begin
    w_win_vld  = 1'b0;
    w_win_idx  = '0;
    w_scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_scan_idx = GW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req_wr_en_i[w_scan_idx]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_scan_idx;
      end
    end
  end

  assign w_to_hit  = (TIMEOUT_CYCLES > 0) && (int'(r_to_cnt) == TIMEOUT_CYCLES - 1);
  assign w_ptr_nxt = GW'((int'(r_grant) + 1) % NUM_REQ);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_win_vld) w_state_nxt = S_ISSUE;
      S_ISSUE: if (mem_wr_valid_i || w_to_hit) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_grant   <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_grant   <= w_win_idx;
            r_addr    <= w_addr_arr[w_win_idx];
            r_to_cnt  <= '0;
            r_to_flag <= 1'b0;
          end
        end
        S_ISSUE: begin
          // A response in the timeout cycle takes priority over the forced completion.
          if (mem_wr_valid_i) begin
            r_data <= mem_wr_data_i;
          end else if (w_to_hit) begin
            r_data    <= '1;
            r_to_flag <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + CW'(1);
          end
        end
        S_RESP:  r_rr_ptr <= w_ptr_nxt;
        default: ;
      endcase
    end
  end

  assign w_grant_oh     = NUM_REQ'(1) << r_grant;
  assign mem_wr_en_o    = (r_state == S_ISSUE);
  assign mem_wr_addr_o  = r_addr;
  assign grant_o        = (r_state != S_IDLE) ? w_grant_oh : '0;
  assign req_wr_valid_o = (r_state == S_RESP) ? w_grant_oh : '0;
  assign req_wr_data_o  = r_data;
  assign busy_o         = (r_state != S_IDLE);
  assign timeout_o      = (r_state == S_RESP) && r_to_flag;

endmodule
